// File: rtl/ags_link_pkg.sv
// Shared definitions for the bit-serial AGS link (receiver and transmitter).
// Holds the receiver state encoding, link constants and the NRZI bit rule.
package ags_link_pkg;

   typedef enum logic [1:0] {
      HUNT,
      DATA,
      PAR
   } rx_state_t;

   localparam logic [7:0] AGS_FLAG       = 8'h7E;
   localparam int         AGS_DATA_W     = 8;
   localparam logic       AGS_IDLE_LEVEL = 1'b0;

   // A level change on the line encodes a 1, a steady level encodes a 0.
   function automatic logic nrzi_bit(input logic lvl, input logic prev);
      return lvl ^ prev;
   endfunction

endpackage

// File: rtl/ags_frame_receiver_if.sv
// Registered byte stream from the AGS receiver to its consumer (valid/ready).
interface ags_frame_receiver_if
   import ags_link_pkg::*;
#(
   parameter int DATA_W = AGS_DATA_W
);

   logic [DATA_W-1:0] data;
   logic              valid;
   logic              ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/ags_frame_receiver_nrzi_decode.sv
// NRZI line decoder: remembers the previous line level and emits the decoded bit
// combinationally from that flop, so it adds no latency.
module ags_nrzi_decode
   import ags_link_pkg::*;
#(
   parameter logic IDLE_LEVEL = AGS_IDLE_LEVEL
) (
   input  logic clk,
   input  logic rst,
   input  logic __in0,
   output logic d
);

   logic prev_lvl_q;
   logic prev_lvl_d;

   always_comb begin
      prev_lvl_d = __in0;
   end

   // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_lvl_q <= IDLE_LEVEL;
      end else begin
         prev_lvl_q <= prev_lvl_d;
      end
   end

   assign d = nrzi_bit(__in0, prev_lvl_q);

endmodule

// File: rtl/ags_frame_receiver.sv
// AGS link receiver: NRZI decode, flag hunt, LSB-first deserialise, registered output.
// Define AGS_RX_PARITY_EN to expect an even-parity bit after each byte and drive frame_err.
module ags_frame_receiver
   import ags_link_pkg::*;
#(
   parameter logic [7:0] FLAG       = AGS_FLAG,
   parameter int         DATA_W     = AGS_DATA_W,
   parameter logic       IDLE_LEVEL = AGS_IDLE_LEVEL
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        __in0,
   ags_frame_receiver_if.master        out_if,
   output logic                        overflow,
   output logic                        frame_err
);

   localparam int             CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   rx_state_t         state_q, state_d;
   logic [7:0]        shreg_q, shreg_d, shreg_shift;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic              overflow_q, overflow_d;
   logic              d;
   logic              commit;
   logic [DATA_W-1:0] commit_byte;
`ifdef AGS_RX_PARITY_EN
   logic              frame_err_q, frame_err_d;
`endif

   ags_nrzi_decode #(.IDLE_LEVEL(IDLE_LEVEL)) u_nrzi (
      .clk   (clk),
      .rst   (rst),
      .__in0 (__in0),
      .d     (d)
   );

   // Flag match uses the value after this cycle's shift, i.e. on the flag's last bit.
   assign shreg_shift = 8'({d, shreg_q} >> 1);

   always_comb begin
      // NOTE: defaults first, so no path through the case leaves a signal unassigned (no latches).
      state_d     = state_q;
      shreg_d     = shreg_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      commit      = 1'b0;
      commit_byte = acc_q;
`ifdef AGS_RX_PARITY_EN
      frame_err_d = 1'b0;
`endif
      case (state_q)
         HUNT: begin
            shreg_d = shreg_shift;
            if (shreg_shift == FLAG) begin
               state_d = DATA;
               cnt_d   = '0;
            end
         end
         DATA: begin
            acc_d[cnt_q] = d;
            cnt_d        = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
`ifdef AGS_RX_PARITY_EN
               state_d = PAR;
`else
               commit      = 1'b1;
               commit_byte = acc_d;
               state_d     = HUNT;
               shreg_d     = '0;
`endif
            end
         end
         PAR: begin
            state_d = HUNT;
            shreg_d = '0;
`ifdef AGS_RX_PARITY_EN
            if (d == ^acc_q) commit = 1'b1;
            else             frame_err_d = 1'b1;
`endif
         end
         default: state_d = HUNT;
      endcase
   end

   // A byte arriving while the previous one is still unconsumed is dropped.
   always_comb begin
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      overflow_d  = overflow_q;
      if (commit && (!out_valid_q || out_if.ready)) begin
         out_data_d  = commit_byte;
         out_valid_d = 1'b1;
      end else if (commit) begin
         overflow_d = 1'b1;
      end else if (out_valid_q && out_if.ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= HUNT;
         shreg_q     <= '0;
         cnt_q       <= '0;
         acc_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         overflow_q  <= overflow_d;
      end
   end

`ifdef AGS_RX_PARITY_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) frame_err_q <= 1'b0;
      else      frame_err_q <= frame_err_d;
   end
   assign frame_err = frame_err_q;
`else
   assign frame_err = 1'b0;
`endif

   assign out_if.data  = out_data_q;
   assign out_if.valid = out_valid_q;
   assign overflow     = overflow_q;

endmodule

// File: tb/tb_ags_frame_receiver.sv
// Directed bench for ags_frame_receiver: NRZI-codes frames on the line and checks
// delivery timing, back-pressure/overflow, mid-frame reset and (parity build) frame_err.
module tb_ags_frame_receiver;
   import ags_link_pkg::*;

`ifdef AGS_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic clk      = 1'b0;
   logic rst      = 1'b0;
   logic in0      = 1'b0;
   logic line_lvl = 1'b0;
   logic overflow;
   logic frame_err;
   logic seen;
   logic last_bit;
   logic [7:0] v;
   int   n_checks = 0;
   int   n_pass   = 0;

   ags_frame_receiver_if #(.DATA_W(8)) out_if ();

   ags_frame_receiver dut (
      .clk       (clk),
      .rst       (rst),
      .__in0     (in0),
      .out_if    (out_if),
      .overflow  (overflow),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
   endtask

   // One decoded bit per clock: toggle the line for a 1, hold it for a 0.
   task automatic send_bit(input logic b);
      @(negedge clk);
      line_lvl = line_lvl ^ b;
      in0      = line_lvl;
   endtask

   task automatic send_bits(input logic [7:0] val, input int n);
      for (int i = 0; i < n; i++) send_bit(val[i]);
   endtask

   task automatic send_frame(input logic [7:0] val);
      send_bits(8'h7E, 8);
      send_bits(val, 8);
      if (PAR_EN) send_bit(^val);
   endtask

   initial begin
      out_if.ready = 1'b0;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_valid", out_if.valid, 0);
      check("rst_data",  out_if.data,  0);
      check("rst_ovf",   overflow,     0);
      check("rst_ferr",  frame_err,    0);
      rst = 1'b1;

      // 1: idle line
      seen = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         seen = seen | out_if.valid;
      end
      check("idle_valid", seen,         0);
      check("idle_state", dut.state_q,  HUNT);
      check("idle_ovf",   overflow,     0);

      // 2: single byte, consumer ready
      out_if.ready = 1'b1;
      send_frame(8'hA5);
      check("t2_not_early", out_if.valid, 0);
      @(negedge clk);
      check("t2_valid", out_if.valid, 1);
      check("t2_data",  out_if.data,  8'hA5);
      @(negedge clk);
      check("t2_clear", out_if.valid, 0);

      // 4: commit coincides with the consumer taking the held byte
      out_if.ready = 1'b0;
      send_frame(8'h12);
      @(negedge clk);
      check("t4_first", out_if.data, 8'h12);
      v = 8'h34;
      send_bits(8'h7E, 8);
      send_bits(v, PAR_EN ? 8 : 7);
      last_bit = PAR_EN ? ^v : v[7];
      send_bit(last_bit);
      out_if.ready = 1'b1;
      check("t4_held", out_if.data, 8'h12);
      @(negedge clk);
      check("t4_valid", out_if.valid, 1);
      check("t4_data",  out_if.data,  8'h34);
      check("t4_ovf",   overflow,     0);
      @(negedge clk);
      check("t4_clear", out_if.valid, 0);

      // 3: back-to-back frames with the consumer stalled
      out_if.ready = 1'b0;
      send_frame(8'h3C);
      send_frame(8'hC3);
      @(negedge clk);
      check("t3_ovf",   overflow,     1);
      check("t3_data",  out_if.data,  8'h3C);
      check("t3_valid", out_if.valid, 1);
      out_if.ready = 1'b1;
      @(negedge clk);
      check("t3_drop", out_if.valid, 0);
      check("t3_hold", out_if.data,  8'h3C);
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         seen = seen | out_if.valid;
      end
      check("t3_no_c3", seen, 0);
      check("t3_sticky", overflow, 1);

      // 5: reset in the middle of byte 0x5A, then a clean 0x11
      send_bits(8'h7E, 8);
      send_bits(8'h5A, 4);
      @(negedge clk);
      rst      = 1'b0;
      in0      = 1'b0;
      line_lvl = 1'b0;
      #1;
      check("t5_rst_valid", out_if.valid, 0);
      check("t5_rst_data",  out_if.data,  0);
      check("t5_rst_ovf",   overflow,     0);
      check("t5_rst_ferr",  frame_err,    0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      send_frame(8'h11);
      check("t5_not_early", out_if.valid, 0);
      @(negedge clk);
      check("t5_valid", out_if.valid, 1);
      check("t5_data",  out_if.data,  8'h11);
      check("t5_ovf",   overflow,     0);

`ifdef AGS_RX_PARITY_EN
      // 6: bad parity is rejected, good parity delivered
      send_bits(8'h7E, 8);
      send_bits(8'h0F, 8);
      send_bit(1'b1);
      @(negedge clk);
      check("t6_ferr",      frame_err,    1);
      check("t6_bad_valid", out_if.valid, 0);
      @(negedge clk);
      check("t6_ferr_pulse", frame_err, 0);
      send_frame(8'h0F);
      @(negedge clk);
      check("t6_valid", out_if.valid, 1);
      check("t6_data",  out_if.data,  8'h0F);
      check("t6_ferr_ok", frame_err,  0);
`else
      check("ferr_tied", frame_err, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
